// File: rtl/shift_reg_slave_pkg.sv
// Shared constants and state type for the shift-register serial slave.
// Synchronizer reset values match the idle levels of the serial bus.
package shift_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int SYNC_DEF  = 2;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  localparam logic SCLK_RST = 1'b0;
  localparam logic CS_N_RST = 1'b1;
  localparam logic SIN_RST  = 1'b0;

endpackage

// File: rtl/shift_reg_slave_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit.
// The reset value lets each chain come up at its line's idle level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) chain <= {STAGES{RST_VAL}};
    else        chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/shift_reg_slave.sv
// Oversampling MSB-first serial slave with a one-word transmit buffer.
// Define SHIFT_REG_SLAVE_STATUS_EN for sticky underrun/frame-error flags.
module shift_reg_slave
  import shift_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sclk_in,
  input  logic             cs_n_in,
  input  logic             serial_in,
  output logic             serial_out,
  output logic             serial_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy
`ifdef SHIFT_REG_SLAVE_STATUS_EN
  ,
  input  logic             status_clr,
  output logic             tx_underrun,
  output logic             rx_frame_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic sclk_s, cs_n_s, sin_s, sclk_d;
  logic rise, fall, load, wr, act, desel;
  state_t state_q, state_d;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-2:0] rx_shift;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] tx_buf;
  logic             tx_full;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_RST)) u_sclk (
    .clk_in(clk_in), .rst_n(rst_n), .d(sclk_in), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_RST)) u_cs_n (
    .clk_in(clk_in), .rst_n(rst_n), .d(cs_n_in), .q(cs_n_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(SIN_RST)) u_sin (
    .clk_in(clk_in), .rst_n(rst_n), .d(serial_in), .q(sin_s)
  );

  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign act     = (state_q == ACTIVE) & ~cs_n_s;
  assign desel   = (state_q == ACTIVE) & cs_n_s;
  assign wr      = tx_valid & ~tx_full;
  assign rx_next = {rx_shift, sin_s};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sclk_d  <= SCLK_RST;
    end else begin
      state_q <= state_d;
      sclk_d  <= sclk_s;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_n_s) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_n_s) state_d = IDLE;
        else if (fall && bit_cnt == '0) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      // An empty buffer at load time sends an all-zero word.
      if (load) tx_shift <= tx_full ? tx_buf : '0;
      else if (act && fall) tx_shift <= tx_shift << 1;
      if (desel) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (act && rise) begin
        rx_shift <= rx_next[WIDTH-2:0];
        if (bit_cnt == LAST) begin
          bit_cnt  <= '0;
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
    end else if (wr) begin
      tx_buf  <= tx_data;
      tx_full <= 1'b1;
    end else if (load) begin
      tx_full <= 1'b0;
    end
  end

  assign serial_oe  = (state_q == ACTIVE);
  assign serial_out = serial_oe & tx_shift[WIDTH-1];
  assign busy       = serial_oe & (bit_cnt != '0);
  assign tx_ready   = ~tx_full;

`ifdef SHIFT_REG_SLAVE_STATUS_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tx_underrun  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (load && !tx_full) tx_underrun <= 1'b1;
      else if (status_clr)  tx_underrun <= 1'b0;
      if (desel && bit_cnt != '0) rx_frame_err <= 1'b1;
      else if (status_clr)        rx_frame_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_slave.sv
// Randomized frame-level bench for shift_reg_slave at sclk = clk_in/8.
// The model tracks words per frame, not bits per clock.
module tb_shift_reg_slave;
  import shift_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_n, sclk_in, cs_n_in, serial_in;
  logic       serial_out, serial_oe, rx_valid;
  logic [7:0] rx_data, tx_data;
  logic       tx_valid, tx_ready, busy;
  logic       status_clr = 1'b0;
  logic       tx_underrun, rx_frame_err;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] rxq[$];
  logic [7:0] pend;
  bit         pend_v = 0;
  bit         m_ur = 0;
  bit         m_fe = 0;

  shift_reg_slave #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .sclk_in(sclk_in),
    .cs_n_in(cs_n_in),
    .serial_in(serial_in),
    .serial_out(serial_out),
    .serial_oe(serial_oe),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy)
`ifdef SHIFT_REG_SLAVE_STATUS_EN
    ,
    .status_clr(status_clr),
    .tx_underrun(tx_underrun),
    .rx_frame_err(rx_frame_err)
`endif
  );

`ifndef SHIFT_REG_SLAVE_STATUS_EN
  assign tx_underrun  = 1'b0;
  assign rx_frame_err = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in)
    if (rst_n && rx_valid) rxq.push_back(rx_data);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_rst_vals();
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_sout", serial_out, 0);
    check("rst_soe", serial_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
  endtask

  task automatic check_status();
`ifdef SHIFT_REG_SLAVE_STATUS_EN
    check("tx_underrun", tx_underrun, m_ur);
    check("rx_frame_err", rx_frame_err, m_fe);
`endif
  endtask

  task automatic clr_status();
`ifdef SHIFT_REG_SLAVE_STATUS_EN
    status_clr = 1'b1;
    @(negedge clk_in);
    status_clr = 1'b0;
    m_ur = 0;
    m_fe = 0;
    @(negedge clk_in);
    check_status();
`endif
  endtask

  task automatic tx_write(input logic [7:0] d);
    for (int k = 0; k < 50 && !tx_ready; k++) @(negedge clk_in);
    check("wr_ready", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk_in);
    tx_valid = 1'b0;
    pend     = d;
    pend_v   = 1;
  endtask

  task automatic frame(input int nbits, input logic [15:0] rxw,
                       input bit coll, input logic [7:0] cw,
                       input bit w2en, input logic [7:0] w2,
                       input int rst_at);
    logic [7:0]  e0, e1, w;
    logic [15:0] ex;
    bit          aborted;
    int          nw;
    aborted = 0;
    e1 = '0;
    rxq.delete();
    if (coll || !pend_v) m_ur = 1;
    e0 = (!coll && pend_v) ? pend : 8'h00;
    pend_v = 0;
    cs_n_in = 1'b0;
    if (coll) begin
      // Offer the word exactly on the cycle the select is acted upon.
      @(negedge clk_in);
      @(negedge clk_in);
      tx_data  = cw;
      tx_valid = 1'b1;
      @(negedge clk_in);
      tx_valid = 1'b0;
      pend     = cw;
      pend_v   = 1;
      check("coll_ready", tx_ready, 0);
      repeat (3) @(negedge clk_in);
    end else begin
      repeat (6) @(negedge clk_in);
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == 8) begin
        if (!pend_v) m_ur = 1;
        e1 = pend_v ? pend : 8'h00;
        pend_v = 0;
      end
      serial_in = rxw[nbits-1-i];
      if (i == 2 && w2en) begin
        check("mid_ready", tx_ready, 1);
        tx_data  = w2;
        tx_valid = 1'b1;
        @(negedge clk_in);
        tx_valid = 1'b0;
        pend     = w2;
        pend_v   = 1;
        repeat (3) @(negedge clk_in);
      end else begin
        repeat (4) @(negedge clk_in);
      end
      w = (i < 8) ? e0 : e1;
      check($sformatf("sout_b%0d", i), serial_out, w[7-(i%8)]);
      check("soe_active", serial_oe, 1);
      if (i == 0) check("ready_after_load", tx_ready, !pend_v);
      if (i == 4) check("busy_mid", busy, 1);
      if (i == 8) check("busy_boundary", busy, 0);
      sclk_in = 1'b1;
      repeat (4) @(negedge clk_in);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_rst_vals();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n   = 1'b1;
        cs_n_in = 1'b1;
        sclk_in = 1'b0;
        pend_v  = 0;
        m_ur    = 0;
        m_fe    = 0;
        aborted = 1;
        break;
      end
      if (i < nbits - 1) sclk_in = 1'b0;
    end
    if (!aborted) begin
      cs_n_in = 1'b1;
      repeat (6) @(negedge clk_in);
      sclk_in = 1'b0;
      if (nbits % 8 != 0) m_fe = 1;
    end
    repeat (6) @(negedge clk_in);
    nw = aborted ? 0 : nbits / 8;
    check("rx_count", rxq.size(), nw);
    for (int k = 0; k < nw; k++) begin
      ex = rxw >> (nbits - 8 * (k + 1));
      if (k < rxq.size()) check("rx_word", rxq[k], ex[7:0]);
    end
    check("soe_idle", serial_oe, 0);
    check("busy_idle", busy, 0);
    check("sout_idle", serial_out, 0);
    check_status();
  endtask

  initial begin
    logic [15:0] r;
    logic [7:0]  a, b;
    int          nb;
    bit          w2e;
    rst_n     = 1'b0;
    sclk_in   = 1'b0;
    cs_n_in   = 1'b1;
    serial_in = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    repeat (3) @(negedge clk_in);
    check_rst_vals();
    rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    check_rst_vals();

    tx_write(8'hA5);
    frame(8, 16'h003C, 0, 0, 0, 0, -1);

    tx_write(8'h12);
    r = 16'($urandom);
    frame(16, r, 0, 0, 1, 8'h34, -1);

    frame(8, 16'($urandom), 0, 0, 0, 0, -1);
    clr_status();

    tx_write(8'($urandom));
    frame(5, 16'($urandom), 0, 0, 0, 0, -1);
    tx_write(8'($urandom));
    frame(8, 16'($urandom), 0, 0, 0, 0, -1);
    clr_status();

    tx_write(8'($urandom));
    frame(8, 16'($urandom), 0, 0, 0, 0, 3);
    tx_write(8'($urandom));
    frame(8, 16'($urandom), 0, 0, 0, 0, -1);

    a = 8'($urandom) | 8'h81;
    frame(8, 16'($urandom), 1, a, 0, 0, -1);
    frame(8, 16'($urandom), 0, 0, 0, 0, -1);
    clr_status();

    for (int n = 0; n < 6; n++) begin
      nb  = ($urandom_range(0, 1) == 1) ? 16 : 8;
      w2e = (nb == 16) && ($urandom_range(0, 1) == 1);
      b   = 8'($urandom);
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      frame(nb, 16'($urandom), 0, 0, w2e, b, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
